// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes,
// state and op-class enums, and the funct decoder.
package mdu_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  typedef enum logic [2:0] {OP_MUL, OP_DIV, OP_MT, OP_MF, OP_ILL} op_e;

  typedef struct packed {
    op_e  op;
    logic sgn;
    logic hi_sel;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] f);
    dec_t d;
    d.op     = OP_ILL;
    d.sgn    = 1'b0;
    d.hi_sel = 1'b0;
    case (f)
      F_MULT:  begin d.op = OP_MUL; d.sgn = 1'b1; end
      F_MULTU: d.op = OP_MUL;
      F_DIV:   begin d.op = OP_DIV; d.sgn = 1'b1; end
      F_DIVU:  d.op = OP_DIV;
      F_MTHI:  begin d.op = OP_MT; d.hi_sel = 1'b1; end
      F_MTLO:  d.op = OP_MT;
      F_MFHI:  begin d.op = OP_MF; d.hi_sel = 1'b1; end
      F_MFLO:  d.op = OP_MF;
      default: d.op = OP_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference if it did not go negative.
module mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  // Trial subtract and restore
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (!trial_s[XLEN]) begin
      rem_next = trial_s[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative HI/LO multiply/divide unit with funct decode, valid/ready
// request handshake, kill abort and illegal-funct signalling.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [XLEN-1:0]    rs_val,
  input  logic [XLEN-1:0]    rt_val,
  input  logic               kill,
  output logic               done,
  output logic [XLEN-1:0]    rd_val,
  output logic               illegal,
  output logic               busy,
  output logic [XLEN-1:0]    hi,
  output logic [XLEN-1:0]    lo
);

  localparam int CW = $clog2(XLEN);

  state_e              state_r;
  logic [CW-1:0]       cnt_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     opnd_r;
  logic                is_div_r;
  logic                neg_q_r;
  logic                neg_r_r;
  logic                dz_r;
  logic [XLEN-1:0]     hi_r;
  logic [XLEN-1:0]     lo_r;
  logic [XLEN-1:0]     rd_r;
  logic                done_r;
  logic                ill_r;

  dec_t                dec_s;
  logic                accept_s;
  logic                rs_neg_s;
  logic                rt_neg_s;
  logic [XLEN-1:0]     rs_mag_s;
  logic [XLEN-1:0]     rt_mag_s;
  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   mul_next_s;
  logic [XLEN-1:0]     div_rem_s;
  logic [XLEN-1:0]     div_quo_s;

  assign dec_s    = decode(6'(funct));
  assign accept_s = req_valid && (state_r == IDLE) && !kill;
  assign rs_neg_s = dec_s.sgn & rs_val[XLEN-1];
  assign rt_neg_s = dec_s.sgn & rt_val[XLEN-1];
  assign rs_mag_s = rs_neg_s ? -rs_val : rs_val;
  assign rt_mag_s = rt_neg_s ? -rt_val : rt_val;

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

  mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem      (acc_r[2*XLEN-1:XLEN]),
    .quo      (acc_r[XLEN-1:0]),
    .divisor  (opnd_r),
    .rem_next (div_rem_s),
    .quo_next (div_quo_s)
  );

  // Control FSM, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      opnd_r   <= {XLEN{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      rd_r     <= {XLEN{1'b0}};
      done_r   <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ill_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (dec_s.op)
              OP_MT: begin
                if (dec_s.hi_sel) hi_r <= rs_val;
                else              lo_r <= rs_val;
                done_r <= 1'b1;
              end
              OP_MF: begin
                rd_r   <= dec_s.hi_sel ? hi_r : lo_r;
                done_r <= 1'b1;
              end
              OP_MUL: begin
                acc_r    <= {{XLEN{1'b0}}, rt_mag_s};
                opnd_r   <= rs_mag_s;
                is_div_r <= 1'b0;
                neg_q_r  <= rs_neg_s ^ rt_neg_s;
                neg_r_r  <= 1'b0;
                dz_r     <= 1'b0;
                cnt_r    <= {CW{1'b0}};
                state_r  <= CALC;
              end
              OP_DIV: begin
                // On divide-by-zero the divisor slot keeps |rs| so HI can be rebuilt
                acc_r    <= {{XLEN{1'b0}}, rs_mag_s};
                opnd_r   <= (rt_val == {XLEN{1'b0}}) ? rs_mag_s : rt_mag_s;
                dz_r     <= (rt_val == {XLEN{1'b0}});
                is_div_r <= 1'b1;
                neg_q_r  <= rs_neg_s ^ rt_neg_s;
                neg_r_r  <= rs_neg_s;
                cnt_r    <= {CW{1'b0}};
                state_r  <= CALC;
              end
              default: ill_r <= 1'b1;
            endcase
          end
        end
        CALC: begin
          if (kill) begin
            state_r <= IDLE;
          end else begin
            acc_r <= is_div_r ? {div_rem_s, div_quo_s} : mul_next_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(XLEN-1)) state_r <= FIX;
          end
        end
        FIX: begin
          state_r <= IDLE;
          if (!kill) begin
            done_r <= 1'b1;
            if (!is_div_r) begin
              {hi_r, lo_r} <= neg_q_r ? -acc_r : acc_r;
            end else if (dz_r) begin
              lo_r <= {XLEN{1'b1}};
              hi_r <= neg_r_r ? -opnd_r : opnd_r;
            end else begin
              lo_r <= neg_q_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
              hi_r <= neg_r_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign illegal   = ill_r;
  assign rd_val    = rd_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: HI/LO moves, signed/unsigned multiply and
// divide, divide-by-zero, overflow, XLEN=8 latency, kill, illegal, reset.
module tb_mdu_ctrl;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, kill, done, illegal, busy;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val, rd_val, hi, lo;

  logic        req_valid8, req_ready8, kill8, done8, illegal8, busy8;
  logic [5:0]  funct8;
  logic [7:0]  rs8, rt8, rd8, hi8, lo8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.XLEN(32), .FUNCT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .kill(kill), .done(done),
    .rd_val(rd_val), .illegal(illegal), .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_ctrl #(.XLEN(8), .FUNCT_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid8), .req_ready(req_ready8),
    .funct(funct8), .rs_val(rs8), .rt_val(rt8), .kill(kill8), .done(done8),
    .rd_val(rd8), .illegal(illegal8), .busy(busy8), .hi(hi8), .lo(lo8)
  );

  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct = f; rs_val = a; rt_val = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rs_val = $urandom(); rt_val = $urandom();
  endtask

  // edges = clock edges after the accept edge until done is seen high
  task automatic wait_done(output int edges, output bit ready_low);
    edges = 0; ready_low = 1'b1;
    while (!done && edges < 80) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) ready_low = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0", hi, lo); end
    checks++; if (rd_val !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd_val); end
    checks++; if ({done, illegal, busy, req_ready} !== 4'b0001) begin errors++; $display("FAIL reset_ctl: got %b want 0001", {done, illegal, busy, req_ready}); end
  endtask

  task automatic test_move;
    int e; bit rl;
    start_op(MTHI, 32'h1234_5678, 32'h0);
    wait_done(e, rl);
    checks++; if (e !== 0) begin errors++; $display("FAIL mthi_lat: got %0d want 0", e); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    start_op(MFHI, 32'h0, 32'h0);
    wait_done(e, rl);
    checks++; if (e !== 0 || rd_val !== 32'h1234_5678) begin errors++; $display("FAIL mfhi: got lat=%0d rd=%h want 0/12345678", e, rd_val); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mfhi_lo: got %h want 0", lo); end
    start_op(MTLO, 32'hA5A5_0F0F, 32'h0);
    start_op(MFLO, 32'h0, 32'h0);
    checks++; if (done !== 1'b1 || rd_val !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mflo: got done=%b rd=%h want 1/a5a50f0f", done, rd_val); end
  endtask

  task automatic test_mult;
    int e; bit rl;
    start_op(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(e, rl);
    checks++; if (e !== 33) begin errors++; $display("FAIL mult_lat: got %0d want 33", e); end
    checks++; if (!rl || req_ready !== 1'b1) begin errors++; $display("FAIL mult_ready: got low_ok=%0d ready=%b want 1/1", rl, req_ready); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_res: got %h_%h want ffffffff_fffffffa", hi, lo); end
    start_op(MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(e, rl);
    checks++; if (e !== 33 || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu: got lat=%0d %h_%h want 33 00000002_fffffffa", e, hi, lo); end
  endtask

  task automatic test_div;
    int e; bit rl;
    start_op(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(e, rl);
    checks++; if (e !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg: got lat=%0d lo=%h hi=%h want 33 fffffffd ffffffff", e, lo, hi); end
    start_op(DIVU, 32'h0000_0007, 32'h0);
    wait_done(e, rl);
    checks++; if (e !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h0000_0007) begin errors++; $display("FAIL divu_zero: got lat=%0d lo=%h hi=%h want 33 ffffffff 00000007", e, lo, hi); end
    start_op(DIV, 32'hFFFF_FFF9, 32'h0);
    wait_done(e, rl);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_zero: got lo=%h hi=%h want ffffffff fffffff9", lo, hi); end
    start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, rl);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin errors++; $display("FAIL div_ovf: got lo=%h hi=%h want 80000000 0", lo, hi); end
    start_op(DIVU, 32'd100, 32'd7);
    wait_done(e, rl);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu: got lo=%h hi=%h want e 2", lo, hi); end
  endtask

  task automatic test_xlen8;
    int e;
    @(negedge clk);
    funct8 = MULT; rs8 = 8'hFE; rt8 = 8'h03; req_valid8 = 1'b1;
    @(posedge clk); #1;
    req_valid8 = 1'b0;
    e = 0;
    while (!done8 && e < 40) begin @(posedge clk); #1; e++; end
    checks++; if (e !== 9) begin errors++; $display("FAIL x8_lat: got %0d want 9", e); end
    checks++; if (hi8 !== 8'hFF || lo8 !== 8'hFA) begin errors++; $display("FAIL x8_res: got %h_%h want ff_fa", hi8, lo8); end
  endtask

  task automatic test_kill;
    int seen = 0;
    start_op(MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL kill_ready: got ready=%b busy=%b want 1/0", req_ready, busy); end
    kill = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen !== 0 || hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL kill_res: got done_cnt=%0d hi=%h lo=%h want 0 2 e", seen, hi, lo); end
    // a request presented together with kill in IDLE is dropped
    @(negedge clk); funct = MTHI; rs_val = 32'hDEAD_BEEF; req_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; kill = 1'b0;
    checks++; if (done !== 1'b0 || hi !== 32'd2) begin errors++; $display("FAIL kill_idle: got done=%b hi=%h want 0 2", done, hi); end
  endtask

  task automatic test_illegal;
    start_op(6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (illegal !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got ill=%b done=%b ready=%b want 1 0 1", illegal, done, req_ready); end
    @(posedge clk); #1;
    checks++; if (illegal !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL illegal_after: got ill=%b hi=%h lo=%h want 0 2 e", illegal, hi, lo); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); funct = MTLO; rs_val = 32'h0BAD_F00D; req_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got done=%b ready=%b want 1 1", done, req_ready); end
    @(negedge clk); funct = MFLO; rs_val = 32'h0;
    @(posedge clk); #1; req_valid = 1'b0;
    checks++; if (done !== 1'b1 || rd_val !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_second: got done=%b rd=%h want 1 0badf00d", done, rd_val); end
  endtask

  task automatic test_reset_mid;
    start_op(MULT, 32'h0000_0011, 32'h0000_0022);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || rd_val !== 32'h0) begin errors++; $display("FAIL rstmid_data: got hi=%h lo=%h rd=%h want 0", hi, lo, rd_val); end
    checks++; if ({done, illegal, busy, req_ready} !== 4'b0001) begin errors++; $display("FAIL rstmid_ctl: got %b want 0001", {done, illegal, busy, req_ready}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; funct = 6'h0; rs_val = 32'h0; rt_val = 32'h0;
    req_valid8 = 1'b0; kill8 = 1'b0; funct8 = 6'h0; rs8 = 8'h0; rt8 = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    test_move();
    test_mult();
    test_div();
    test_xlen8();
    test_kill();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
